// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, register-file depth and op codes.
package alu_pkg;

  localparam int unsigned W     = 16;
  localparam int unsigned NREGS = 8;
  localparam int unsigned AW    = $clog2(NREGS);
  localparam int unsigned OPW   = 4;

  localparam logic [OPW-1:0] OP_ADD = 4'h0;
  localparam logic [OPW-1:0] OP_SUB = 4'h1;
  localparam logic [OPW-1:0] OP_AND = 4'h2;
  localparam logic [OPW-1:0] OP_OR  = 4'h3;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: two operand read ports, a debug read port, r0 fixed at 0,
// writeback and direct load both land in one edge with writeback winning on a tie.
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr,
  output logic [W-1:0]  ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [W-1:0]  rb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data
);

  logic [W-1:0] rf [NREGS];

  // Entry 0 is only ever cleared, so it reads as zero forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (wb_en && (wb_addr == AW'(i))) begin
          rf[i] <= wb_data;
        end else if (ld_en && (ld_addr == AW'(i))) begin
          rf[i] <= ld_data;
        end
      end
    end
  end

  assign ra_data  = rf[ra_addr];
  assign rb_data  = rf[rb_addr];
  assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu_cmd_stage.sv
// Command-issue stage in front of the 16-bit ALU: accepts reg-reg commands, drives
// registered operands, captures the result and writes it back. Optional: ALU_STICKY_OVF_EN.
module alu_cmd_stage
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [OPW-1:0] cmd_op,
  input  logic [AW-1:0]  cmd_rd,
  input  logic [AW-1:0]  cmd_ra,
  input  logic [AW-1:0]  cmd_rb,
  input  logic           ld_valid,
  input  logic [AW-1:0]  ld_addr,
  input  logic [W-1:0]   ld_data,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_ctrl,
  input  logic [W-1:0]   alu_s,
  input  logic           alu_ovf,
  input  logic           alu_zero,
  output logic           res_valid,
  output logic [W-1:0]   res_data,
  output logic           res_ovf,
  output logic           res_zero,
  input  logic [AW-1:0]  dbg_addr,
  output logic [W-1:0]   dbg_data
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic           ovf_clr,
  output logic           ovf_sticky
`endif
);

  state_t        state, state_nx;
  logic          accept_c;
  logic          wb_c;
  logic [AW-1:0] rd_q;
  logic [W-1:0]  ra_data, rb_data;

  // A direct load owns the cycle, so commands wait for it.
  assign cmd_ready = (state == IDLE) && !ld_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    wb_c     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept_c = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        wb_c     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operands are frozen at accept; results are captured at the end of EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      rd_q      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
      res_zero  <= 1'b0;
    end else begin
      if (accept_c) begin
        alu_a    <= ra_data;
        alu_b    <= rb_data;
        alu_ctrl <= cmd_op;
        rd_q     <= cmd_rd;
      end
      res_valid <= wb_c;
      if (wb_c) begin
        res_data <= alu_s;
        res_ovf  <= alu_ovf;
        res_zero <= alu_zero;
      end
    end
  end

`ifdef ALU_STICKY_OVF_EN
  // Set takes priority so a clear cannot hide an overflow landing the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  ovf_sticky <= 1'b0;
    else if (wb_c && alu_ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr)         ovf_sticky <= 1'b0;
  end
`endif

  alu_regfile u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (cmd_ra),
    .ra_data  (ra_data),
    .rb_addr  (cmd_rb),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wb_en    (wb_c),
    .wb_addr  (rd_q),
    .wb_data  (alu_s),
    .ld_en    (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

endmodule

// File: tb/tb_alu_cmd_stage.sv
// Bench for alu_cmd_stage: behavioural ALU + register-file model, per-cycle compare,
// directed scenarios and a randomized phase. Build with ALU_STICKY_OVF_EN to cover the sticky flag.
module tb_alu_cmd_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [2:0]  cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [15:0] alu_s;
  logic        alu_ovf, alu_zero;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ovf, res_zero;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
`ifdef ALU_STICKY_OVF_EN
  logic        ovf_clr = 1'b0;
  logic        ovf_sticky;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_cmd_stage dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_ra    (cmd_ra),
    .cmd_rb    (cmd_rb),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_s     (alu_s),
    .alu_ovf   (alu_ovf),
    .alu_zero  (alu_zero),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .res_zero  (res_zero),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
`ifdef ALU_STICKY_OVF_EN
    ,
    .ovf_clr   (ovf_clr),
    .ovf_sticky(ovf_sticky)
`endif
  );

  // Stand-in for the downstream ALU: returns {ovf, zero, s}.
  function automatic logic [17:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic        v;
    v = 1'b0;
    case (op)
      4'h0: begin s = a + b; v = (a[15] == b[15]) && (s[15] != a[15]); end
      4'h1: begin s = a - b; v = (a[15] != b[15]) && (s[15] != a[15]); end
      4'h2: s = a & b;
      4'h3: s = a | b;
      4'h4: s = a ^ b;
      default: s = a;
    endcase
    return {v, (s == 16'h0), s};
  endfunction

  assign {alu_ovf, alu_zero, alu_s} = alu_fn(alu_ctrl, alu_a, alu_b);

  // Reference model state.
  logic [15:0] m_rf [8] = '{default: 16'h0};
  bit          m_busy = 0;
  logic [15:0] m_a = '0, m_b = '0;
  logic [3:0]  m_op = '0;
  logic [2:0]  m_rd = '0;
  bit          m_res_valid = 0;
  logic [15:0] m_res_data = '0;
  bit          m_res_ovf = 0, m_res_zero = 0;
  bit          m_sticky = 0;
  logic [17:0] m_r;
  logic [15:0] m_na, m_nb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rf = '{default: 16'h0};
      m_busy = 0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0;
      m_res_valid = 0; m_res_data = '0; m_res_ovf = 0; m_res_zero = 0;
      m_sticky = 0;
    end else begin
      m_na = m_rf[cmd_ra];
      m_nb = m_rf[cmd_rb];
      m_r  = alu_fn(m_op, m_a, m_b);
      if (ld_valid && ld_addr != 3'd0) m_rf[ld_addr] = ld_data;
`ifdef ALU_STICKY_OVF_EN
      if (ovf_clr) m_sticky = 0;
`endif
      m_res_valid = m_busy;
      if (m_busy) begin
        if (m_rd != 3'd0) m_rf[m_rd] = m_r[15:0];
        m_res_data = m_r[15:0];
        m_res_zero = m_r[16];
        m_res_ovf  = m_r[17];
        if (m_r[17]) m_sticky = 1;
        m_busy = 0;
      end else if (cmd_valid && !ld_valid) begin
        m_busy = 1;
        m_a = m_na; m_b = m_nb; m_op = cmd_op; m_rd = cmd_rd;
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: all outputs against the model.
  always @(negedge clk) begin
    chk("cmd_ready", 16'(cmd_ready), 16'(!m_busy && !ld_valid));
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_ctrl", 16'(alu_ctrl), 16'(m_op));
    chk("res_valid", 16'(res_valid), 16'(m_res_valid));
    chk("res_data", res_data, m_res_data);
    chk("res_ovf", 16'(res_ovf), 16'(m_res_ovf));
    chk("res_zero", 16'(res_zero), 16'(m_res_zero));
    chk("dbg_data", dbg_data, m_rf[dbg_addr]);
`ifdef ALU_STICKY_OVF_EN
    chk("ovf_sticky", 16'(ovf_sticky), 16'(m_sticky));
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    cyc();
    ld_valid = 1'b0;
  endtask

  // Presents a command and returns one step into the EXEC cycle.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    bit done;
    done = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (cmd_ready) done = 1;
      cyc();
    end
    cmd_valid = 1'b0;
    if (!done) chk("issue_timeout", 16'h0, 16'h1);
  endtask

  initial begin
    #1 rst = 1'b1;
    cyc(); cyc();
    chk("rst_res_valid", 16'(res_valid), 16'h0);
    chk("rst_alu_a", alu_a, 16'h0);
    chk("rst_cmd_ready", 16'(cmd_ready), 16'h1);
    rst = 1'b0;
    cyc();

    // Basic add.
    load(3'd1, 16'h0005); load(3'd2, 16'h0003);
    issue(4'h0, 3'd3, 3'd1, 3'd2);
    cyc();
    chk("add_valid", 16'(res_valid), 16'h1);
    chk("add_data", res_data, 16'h0008);
    chk("add_zero", 16'(res_zero), 16'h0);
    dbg_addr = 3'd3; #1;
    chk("add_dbg_r3", dbg_data, 16'h0008);
    cyc();
    chk("add_pulse_end", 16'(res_valid), 16'h0);
    chk("add_data_hold", res_data, 16'h0008);

    // Signed overflow.
    load(3'd1, 16'h7FFF); load(3'd2, 16'h0001);
    issue(4'h0, 3'd4, 3'd1, 3'd2);
    cyc();
    chk("ovf_data", res_data, 16'h8000);
    chk("ovf_flag", 16'(res_ovf), 16'h1);
`ifdef ALU_STICKY_OVF_EN
    chk("sticky_set", 16'(ovf_sticky), 16'h1);
    cyc();
    chk("sticky_hold", 16'(ovf_sticky), 16'h1);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    chk("sticky_clr", 16'(ovf_sticky), 16'h0);
`endif

    // Write to r0 is dropped but still reported.
    issue(4'h1, 3'd0, 3'd2, 3'd2);
    cyc();
    chk("r0_valid", 16'(res_valid), 16'h1);
    chk("r0_data", res_data, 16'h0000);
    chk("r0_zero", 16'(res_zero), 16'h1);
    dbg_addr = 3'd0; #1;
    chk("r0_dbg", dbg_data, 16'h0000);

    // A pending load blocks acceptance.
    cmd_valid = 1'b1; cmd_op = 4'h0; cmd_rd = 3'd6; cmd_ra = 3'd1; cmd_rb = 3'd1;
    ld_valid = 1'b1; ld_addr = 3'd7; ld_data = 16'hAAAA;
    #1 chk("ld_blocks_ready", 16'(cmd_ready), 16'h0);
    cyc(); cyc();
    chk("ld_blocks_accept", 16'(alu_ctrl), 16'h1);
    ld_valid = 1'b0;
    #1 chk("ready_after_ld", 16'(cmd_ready), 16'h1);
    cyc();
    cmd_valid = 1'b0;
    chk("held_accept_ctrl", 16'(alu_ctrl), 16'h0);
    chk("held_accept_a", alu_a, 16'h7FFF);
    cyc();
    chk("held_result", res_data, 16'hFFFE);
    dbg_addr = 3'd7; #1;
    chk("held_ld_r7", dbg_data, 16'hAAAA);

    // Load and writeback to the same register on one edge.
    issue(4'h0, 3'd3, 3'd1, 3'd2);
    ld_valid = 1'b1; ld_addr = 3'd3; ld_data = 16'h1234;
    cyc();
    ld_valid = 1'b0;
    dbg_addr = 3'd3; #1;
    chk("wb_beats_ld", dbg_data, 16'h8000);

    // Load to a source register during EXEC leaves the in-flight command alone.
    issue(4'h0, 3'd5, 3'd1, 3'd2);
    ld_valid = 1'b1; ld_addr = 3'd1; ld_data = 16'h0000;
    cyc();
    ld_valid = 1'b0;
    chk("inflight_data", res_data, 16'h8000);
    dbg_addr = 3'd1; #1;
    chk("inflight_ld_r1", dbg_data, 16'h0000);

    // Back-to-back dependent commands, results two cycles apart.
    load(3'd1, 16'h0005); load(3'd2, 16'h0003);
    issue(4'h0, 3'd5, 3'd1, 3'd2);
    cmd_valid = 1'b1; cmd_op = 4'h0; cmd_rd = 3'd6; cmd_ra = 3'd5; cmd_rb = 3'd5;
    #1 chk("b2b_busy", 16'(cmd_ready), 16'h0);
    cyc();
    chk("b2b_first_valid", 16'(res_valid), 16'h1);
    chk("b2b_first_data", res_data, 16'h0008);
    cyc();
    cmd_valid = 1'b0;
    chk("b2b_gap", 16'(res_valid), 16'h0);
    cyc();
    chk("b2b_second_valid", 16'(res_valid), 16'h1);
    chk("b2b_second_data", res_data, 16'h0010);

    // Reset during EXEC aborts the command.
    cyc();
    issue(4'h0, 3'd2, 3'd1, 3'd1);
    rst = 1'b1;
    #1 chk("abort_valid", 16'(res_valid), 16'h0);
    cyc();
    dbg_addr = 3'd1; #1;
    chk("abort_rf_clear", dbg_data, 16'h0000);
    rst = 1'b0;
    #1 chk("abort_ready", 16'(cmd_ready), 16'h1);
    cyc();
    chk("abort_no_result", 16'(res_valid), 16'h0);
    dbg_addr = 3'd2; #1;
    chk("abort_no_wb", dbg_data, 16'h0000);

    // Randomized phase, checked every cycle by the model.
    for (int k = 0; k < 3000; k++) begin
      rst       = ($urandom_range(0, 199) == 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 4'($urandom_range(0, 7));
      cmd_rd    = 3'($urandom_range(0, 7));
      cmd_ra    = 3'($urandom_range(0, 7));
      cmd_rb    = 3'($urandom_range(0, 7));
      ld_valid  = ($urandom_range(0, 3) == 0);
      ld_addr   = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ld_data = 16'h7FFF;
        1: ld_data = 16'h8000;
        2: ld_data = 16'hFFFF;
        3: ld_data = 16'h0001;
        default: ld_data = 16'($urandom);
      endcase
      dbg_addr  = 3'($urandom_range(0, 7));
`ifdef ALU_STICKY_OVF_EN
      ovf_clr   = ($urandom_range(0, 15) == 0);
`endif
      cyc();
    end
    rst = 1'b0; cmd_valid = 1'b0; ld_valid = 1'b0;
`ifdef ALU_STICKY_OVF_EN
    ovf_clr = 1'b0;
`endif
    cyc(); cyc(); cyc();
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_stage.md
# alu_cmd_stage

Command-issue stage directly upstream of the team's 16-bit ALU. Holds an 8×16 register file, accepts register-to-register commands over a valid/ready handshake, and drives registered A/B/ALUCtrl into the ALU. Captures the ALU's S/Overflow/Zero one cycle later, writes S back to the destination register and reports it on a one-cycle result strobe.

## Interface
- NREGS, 8, register-file depth; fixed at 8 (3-bit addresses)
- W, 16, datapath width; must match the ALU
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  stage can accept a command this cycle
- cmd_op  in  4  ALU control code, passed to ALUCtrl unchanged
- cmd_rd / cmd_ra / cmd_rb  in  3 each  destination and source register indices
- ld_valid  in  1  direct register load strobe
- ld_addr  in  3  load target index
- ld_data  in  16  load value
- alu_a / alu_b  out  16  registered operands to the ALU
- alu_ctrl  out  4  registered control to the ALU
- alu_s  in  16  ALU result (combinational from alu_a/alu_b/alu_ctrl)
- alu_ovf / alu_zero  in  1  ALU Overflow / Zero
- res_valid  out  1  one-cycle strobe: result written back
- res_data  out  16  written-back value
- res_ovf / res_zero  out  1  flags captured with res_data
- dbg_addr  in  3  debug read index
- dbg_data  out  16  combinational read of rf[dbg_addr]

## Operation
- FSM states: IDLE, EXEC.
- cmd_ready = (state==IDLE) && !ld_valid.
- IDLE, cmd_valid && cmd_ready: latch alu_a←rf[ra], alu_b←rf[rb], alu_ctrl←cmd_op, rd; go to EXEC.
- EXEC, one cycle only: at the ending edge, rf[rd]←alu_s (unless rd==0), res_data←alu_s, res_ovf←alu_ovf, res_zero←alu_zero, res_valid←1; return to IDLE.
- res_valid high for exactly one cycle; res_data and res_ovf/res_zero hold until the next result.
- Register 0 reads as 0; writes to it are dropped (command still completes, res_valid still pulses with the real alu_s).
- ld_valid writes rf[ld_addr]←ld_data at the next edge in any state. Address 0 is ignored.
- ld_valid and writeback to the same index on the same edge: writeback wins.
- Operands are sampled at accept. A load landing during EXEC does not alter the in-flight command.
- alu_a/alu_b/alu_ctrl hold their last values in IDLE.
- No arithmetic inside the block; all width/overflow semantics belong to the ALU.

## Timing
- Reset values: state IDLE, rf all 0, alu_a=alu_b=0, alu_ctrl=0, res_valid=0, res_data=0, res_ovf=res_zero=0, sticky=0. cmd_ready=1 once rst deasserts, provided ld_valid=0.
- Command accepted at edge N: ALU inputs valid after N; writeback and res_valid=1 in the cycle after edge N+1.
- Throughput: one command per 2 cycles. cmd_ready is low during EXEC.
- Back-to-back dependent commands are safe: the second is accepted in IDLE, after writeback.
- rst during EXEC: command aborted, no writeback, no res_valid.

## Configuration
- ALU_STICKY_OVF_EN defined: adds input ovf_clr (1) and output ovf_sticky (1). ovf_sticky sets on any writeback with alu_ovf=1 and clears on ovf_clr. Set wins over a simultaneous clear. Reset value 0.
- Not defined: neither port exists and there is no sticky register.

## Structure
- Shared package alu_pkg: W, NREGS, and the op-code constants OP_ADD=4'h0, OP_SUB=4'h1, OP_AND=4'h2, OP_OR=4'h3, shared with the ALU.
- One sub-module, alu_regfile: 8×16, two async read ports plus a debug read port, one write port with writeback-over-load priority and r0 hardwired to 0.

## Test plan
- Reset mid-EXEC (accept a command, assert rst one cycle later) -> no res_valid, all rf reads 0, cmd_ready=1 after release.
- ld r1=0x0005, ld r2=0x0003; cmd OP_ADD rd=3 ra=1 rb=2 -> res_valid one cycle after EXEC, res_data=0x0008, dbg r3=0x0008, res_zero=0.
- r1=0x7FFF, r2=0x0001, OP_ADD rd=4 -> res_data=0x8000, res_ovf=1. With ALU_STICKY_OVF_EN, ovf_sticky=1 until ovf_clr.
- OP_SUB rd=0 ra=2 rb=2 (r2=0x0003) -> res_data=0, res_zero=1, dbg r0 still 0.
- cmd_valid held high with ld_valid=1 -> cmd_ready=0, no accept until ld_valid drops. Load to r3 on the same edge as a writeback to r3 -> r3 holds the writeback value.
- Two back-to-back commands, second reading the first's rd -> second uses the updated value. Results 2 cycles apart.
